// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the stall/flush sequencer.
// The master side is the datapath, the slave side is pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic                  ex_mem_read;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  br_taken;
    logic                  dmem_req;
    logic                  dmem_ack;

    logic                  pc_en;
    logic                  if_id_en;
    logic                  id_ex_en;
    logic                  ex_mem_en;
    logic                  mem_wb_en;
    logic                  if_id_flush;
    logic                  id_ex_flush;
    logic                  mem_wb_bubble;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;
    logic [1:0]            ctrl_state;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
               br_taken, dmem_req, dmem_ack,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush,
               id_ex_flush, mem_wb_bubble, stall_cnt, flush_cnt, ctrl_state
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
               br_taken, dmem_req, dmem_ack,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush,
               id_ex_flush, mem_wb_bubble, stall_cnt, flush_cnt, ctrl_state
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, taken-branch flushes,
// data-memory wait stalls, plus saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W   = 5,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FCNT_W-1:0] FCNT_LOAD = FCNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_t;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_bubble;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN      = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam ctrl_t CTRL_STALL    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam ctrl_t CTRL_FLUSH    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam ctrl_t CTRL_LOAD_USE = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [FCNT_W-1:0] r_fcnt;
    logic [FCNT_W-1:0] w_fcnt_nxt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;
    ctrl_t             w_ctrl;
    ctrl_t             w_ctrl_out;
    logic              w_flush_evt;
    logic              w_run_dec;
    logic              w_mem_stall;
    logic              w_load_use;

    assign w_mem_stall = bus.dmem_req && !bus.dmem_ack;
    assign w_load_use  = bus.ex_mem_read && (bus.ex_rd != '0) &&
                         ((bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                          (bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd)));

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_ctrl      = CTRL_RUN;
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        w_flush_evt = 1'b0;
        w_run_dec   = 1'b0;

        unique case (r_state)
            ST_RUN: w_run_dec = 1'b1;
            ST_MEM_WAIT: begin
                if (!bus.dmem_ack) w_ctrl = CTRL_STALL;
                else               w_run_dec = 1'b1;
            end
            ST_FLUSH: begin
                if (w_mem_stall) begin
                    w_ctrl      = CTRL_STALL;
                    w_state_nxt = ST_MEM_WAIT;
                end else begin
                    w_ctrl     = CTRL_FLUSH;
                    w_fcnt_nxt = r_fcnt - 1'b1;
                    if (r_fcnt == FCNT_W'(1)) w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase

        // Shared RUN decode; an interrupted flush (fcnt!=0) resumes once memory answers.
        if (w_run_dec) begin
            if (w_mem_stall) begin
                w_ctrl      = CTRL_STALL;
                w_state_nxt = ST_MEM_WAIT;
            end else begin
                w_state_nxt = (r_fcnt != '0) ? ST_FLUSH : ST_RUN;
                if (bus.br_taken) begin
                    w_ctrl      = CTRL_FLUSH;
                    w_flush_evt = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        w_fcnt_nxt  = FCNT_LOAD;
                        w_state_nxt = ST_FLUSH;
                    end
                end else if (w_load_use) begin
                    w_ctrl = CTRL_LOAD_USE;
                end
            end
        end
    end

    // Reset forces the safe stall pattern without waiting for a clock edge.
    assign w_ctrl_out = rst ? w_ctrl : CTRL_STALL;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_RUN;
            r_fcnt      <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
            if (!w_ctrl.pc_en && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush_evt && (r_flush_cnt != '1))   r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign bus.pc_en         = w_ctrl_out.pc_en;
    assign bus.if_id_en      = w_ctrl_out.if_id_en;
    assign bus.id_ex_en      = w_ctrl_out.id_ex_en;
    assign bus.ex_mem_en     = w_ctrl_out.ex_mem_en;
    assign bus.mem_wb_en     = w_ctrl_out.mem_wb_en;
    assign bus.if_id_flush   = w_ctrl_out.if_id_flush;
    assign bus.id_ex_flush   = w_ctrl_out.id_ex_flush;
    assign bus.mem_wb_bubble = w_ctrl_out.mem_wb_bubble;
    assign bus.stall_cnt     = r_stall_cnt;
    assign bus.flush_cnt     = r_flush_cnt;
    assign bus.ctrl_state    = r_state;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: load-use, memory wait, branch flush, priority,
// asynchronous reset mid-operation and counter saturation (second instance with CNT_W=4).
module tb_pipe_hazard_ctrl;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    // Control vector order: pc_en if_id_en id_ex_en ex_mem_en mem_wb_en if_id_flush id_ex_flush mem_wb_bubble
    localparam logic [7:0] C_RUN   = 8'hF8;
    localparam logic [7:0] C_STALL = 8'h01;
    localparam logic [7:0] C_LU    = 8'h3A;
    localparam logic [7:0] C_FLUSH = 8'hFE;

    pipe_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(16)) bus  ();
    pipe_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(4))  bus4 ();

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .FLUSH_CYCLES(2), .CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    logic [7:0] ctrl;
    logic [7:0] ctrl4;
    assign ctrl  = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
                    bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_bubble};
    assign ctrl4 = {bus4.pc_en, bus4.if_id_en, bus4.id_ex_en, bus4.ex_mem_en, bus4.mem_wb_en,
                    bus4.if_id_flush, bus4.id_ex_flush, bus4.mem_wb_bubble};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic clear_inputs();
        bus.id_rs1 = '0;  bus.id_rs2 = '0;  bus.id_uses_rs1 = 1'b0; bus.id_uses_rs2 = 1'b0;
        bus.ex_mem_read = 1'b0; bus.ex_rd = '0; bus.br_taken = 1'b0;
        bus.dmem_req = 1'b0; bus.dmem_ack = 1'b0;
        bus4.id_rs1 = '0; bus4.id_rs2 = '0; bus4.id_uses_rs1 = 1'b0; bus4.id_uses_rs2 = 1'b0;
        bus4.ex_mem_read = 1'b0; bus4.ex_rd = '0; bus4.br_taken = 1'b0;
        bus4.dmem_req = 1'b0; bus4.dmem_ack = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2);
        bus.ex_mem_read = 1'b1; bus.ex_rd = rd;
        bus.id_rs1 = rs1; bus.id_uses_rs1 = u1;
        bus.id_rs2 = rs2; bus.id_uses_rs2 = u2;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b0;
        clear_inputs();

        // Reset state
        #2;
        check("rst_ctrl", ctrl, C_STALL);
        check("rst_state", bus.ctrl_state, 0);
        check("rst_stall_cnt", bus.stall_cnt, 0);
        check("rst_flush_cnt", bus.flush_cnt, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("idle_ctrl", ctrl, C_RUN);
        tick();

        // 1: load-use on rs1, then ex_rd=0, rs2 match, rs2 not used
        set_load_use(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        @(negedge clk);
        check("lu_rs1_ctrl", ctrl, C_LU);
        check("lu_rs1_cnt_before", bus.stall_cnt, 0);
        tick();
        set_load_use(5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
        @(negedge clk);
        check("lu_rd0_ctrl", ctrl, C_RUN);
        check("lu_rs1_cnt_after", bus.stall_cnt, 1);
        tick();
        set_load_use(5'd7, 5'd5, 1'b0, 5'd7, 1'b1);
        @(negedge clk);
        check("lu_rd0_cnt", bus.stall_cnt, 1);
        check("lu_rs2_ctrl", ctrl, C_LU);
        tick();
        set_load_use(5'd7, 5'd5, 1'b1, 5'd7, 1'b0);
        @(negedge clk);
        check("lu_rs2_unused_ctrl", ctrl, C_RUN);
        check("lu_rs2_cnt", bus.stall_cnt, 2);
        tick();

        // 2: memory wait of three cycles, ack on the fourth
        do_reset();
        bus.dmem_req = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check($sformatf("mw_ctrl_c%0d", c), ctrl, C_STALL);
            check($sformatf("mw_state_c%0d", c), bus.ctrl_state, (c == 1) ? 0 : 1);
            tick();
        end
        bus.dmem_ack = 1'b1;
        @(negedge clk);
        check("mw_ack_ctrl", ctrl, C_RUN);
        check("mw_ack_state", bus.ctrl_state, 1);
        tick();
        clear_inputs();
        @(negedge clk);
        check("mw_end_state", bus.ctrl_state, 0);
        check("mw_stall_cnt", bus.stall_cnt, 3);
        tick();

        // 3: branch flush, two cycles
        do_reset();
        bus.br_taken = 1'b1;
        @(negedge clk);
        check("br_c1_ctrl", ctrl, C_FLUSH);
        check("br_c1_state", bus.ctrl_state, 0);
        tick();
        bus.br_taken = 1'b0;
        @(negedge clk);
        check("br_c2_ctrl", ctrl, C_FLUSH);
        check("br_c2_state", bus.ctrl_state, 2);
        tick();
        @(negedge clk);
        check("br_end_ctrl", ctrl, C_RUN);
        check("br_end_state", bus.ctrl_state, 0);
        check("br_flush_cnt", bus.flush_cnt, 1);
        tick();

        // 4: memory wait beats branch; branch beats load-use
        do_reset();
        bus.br_taken = 1'b1; bus.dmem_req = 1'b1;
        @(negedge clk);
        check("pri_w1_ctrl", ctrl, C_STALL);
        tick();
        @(negedge clk);
        check("pri_w2_ctrl", ctrl, C_STALL);
        check("pri_w2_state", bus.ctrl_state, 1);
        tick();
        bus.dmem_ack = 1'b1;
        @(negedge clk);
        check("pri_ack_ctrl", ctrl, C_FLUSH);
        tick();
        clear_inputs();
        set_load_use(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        @(negedge clk);
        check("pri_flush_lu_ignored", ctrl, C_FLUSH);
        check("pri_flush_state", bus.ctrl_state, 2);
        check("pri_flush_cnt", bus.flush_cnt, 1);
        tick();
        bus.br_taken = 1'b1;
        @(negedge clk);
        check("pri_br_lu_ctrl", ctrl, C_FLUSH);
        check("pri_br_lu_state", bus.ctrl_state, 0);
        tick();
        clear_inputs();
        @(negedge clk);
        check("pri_flush_cnt2", bus.flush_cnt, 2);
        check("pri_stall_cnt", bus.stall_cnt, 2);
        tick();

        // 5: asynchronous reset in MEM_WAIT and in FLUSH
        do_reset();
        bus.dmem_req = 1'b1;
        tick();
        @(negedge clk);
        check("ar_mw_state_pre", bus.ctrl_state, 1);
        #2 rst = 1'b0;
        #1;
        check("ar_mw_ctrl", ctrl, C_STALL);
        check("ar_mw_state", bus.ctrl_state, 0);
        check("ar_mw_stall_cnt", bus.stall_cnt, 0);
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("ar_mw_post_ctrl", ctrl, C_RUN);
        tick();
        bus.br_taken = 1'b1;
        tick();
        bus.br_taken = 1'b0;
        @(negedge clk);
        check("ar_fl_state_pre", bus.ctrl_state, 2);
        #2 rst = 1'b0;
        #1;
        check("ar_fl_ctrl", ctrl, C_STALL);
        check("ar_fl_state", bus.ctrl_state, 0);
        check("ar_fl_flush_cnt", bus.flush_cnt, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("ar_fl_post_ctrl", ctrl, C_RUN);
        check("ar_fl_post_state", bus.ctrl_state, 0);
        tick();

        // 6: saturation of the 4-bit stall counter
        do_reset();
        bus4.dmem_req = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 14) check("sat_cnt_14", bus4.stall_cnt, 14);
        end
        @(negedge clk);
        check("sat_cnt_20", bus4.stall_cnt, 15);
        check("sat_ctrl", ctrl4, C_STALL);
        check("sat_other_dut_idle", bus.stall_cnt, 0);
        tick();
        tick();
        check("sat_cnt_held", bus4.stall_cnt, 15);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
